// File: rtl/udp_ctrl_pkg.sv
// udp_ctrl_pkg: shared types and constants for the UDP packet-RAM ownership controller.
package udp_ctrl_pkg;

  localparam int RAM_AW_DEF    = 9;
  localparam int PRELOAD_WORDS = 5;

  localparam logic [15:0] DEF_DATA_LEN  = 16'd28;
  localparam logic [15:0] DEF_TOTAL_LEN = 16'd48;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RX_FILL = 3'd2,
    ST_TX_REQ  = 3'd3,
    ST_TX_WAIT = 3'd4
  } state_e;

  // Default payload "HELLO ALINX AX516 \n\r", one 32-bit word per index.
  function automatic logic [31:0] preload_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'h48454C4C;  // "HELL"
      3'd1:    return 32'h4F20414C;  // "O AL"
      3'd2:    return 32'h494E5820;  // "INX "
      3'd3:    return 32'h41583531;  // "AX51"
      3'd4:    return 32'h36200A0D;  // "6 \n\r"
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/udp_beacon_timer.sv
// udp_beacon_timer: saturating up-counter; expired stays high until cleared.
module udp_beacon_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Count while enabled, park at LAST, clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/udp_buf_ctrl.sv
// udp_buf_ctrl: owns the UDP packet RAM write port and schedules transmissions.
// Preloads a default payload, hands the write port to the rx engine for one
// packet, then echoes it. Optional periodic beacon is built when UDP_BEACON_EN
// is defined; without it, transmissions happen only as echoes after rx_done.
module udp_buf_ctrl
  import udp_ctrl_pkg::*;
#(
  parameter int RAM_AW        = RAM_AW_DEF,
  parameter int PRELOAD_BASE  = 1,
  parameter int BEACON_CYCLES = 125000000,
  parameter int TX_TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_start,
  input  logic              rx_wr_valid,
  input  logic [RAM_AW-1:0] rx_wr_addr,
  input  logic [31:0]       rx_wr_data,
  input  logic              rx_done,
  input  logic              rx_abort,
  input  logic [15:0]       rx_data_length,
  input  logic [15:0]       rx_total_length,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [15:0]       rx_drop_cnt,
  output logic [2:0]        state_o
);

  localparam int TO_W = $clog2(TX_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              tx_start_q, tx_start_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_waddr_q, ram_waddr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [15:0]       dlen_q, dlen_d;
  logic [15:0]       tlen_q, tlen_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              drop_q, drop_d;
  logic              rose_q, rose_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              beacon_exp;
  logic              beacon_clr;

  // FSM next state, RAM write port, tx request and length bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_start_d  = 1'b0;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    dlen_d      = dlen_q;
    tlen_d      = tlen_q;
    rose_d      = rose_q;
    to_cnt_d    = to_cnt_q;
    beacon_clr  = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_we_d    = 1'b1;
        ram_waddr_d = RAM_AW'(PRELOAD_BASE) + RAM_AW'(idx_q);
        ram_wdata_d = preload_word(idx_q);
        dlen_d      = DEF_DATA_LEN;
        tlen_d      = DEF_TOTAL_LEN;
        if (idx_q == 3'(PRELOAD_WORDS - 1)) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      // rx takes priority; an expired beacon simply stays pending.
      ST_IDLE: begin
        if (rx_start)        state_d = ST_RX_FILL;
        else if (beacon_exp) state_d = ST_TX_REQ;
      end
      ST_RX_FILL: begin
        // A second rx_start mid-packet marks the rest as dropped: stop writing.
        if (rx_wr_valid && !drop_q) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = rx_wr_addr;
          ram_wdata_d = rx_wr_data;
        end
        if (rx_abort) begin
          idx_d   = '0;
          dlen_d  = DEF_DATA_LEN;
          tlen_d  = DEF_TOTAL_LEN;
          state_d = ST_INIT;
        end else if (rx_done) begin
          dlen_d  = rx_data_length;
          tlen_d  = rx_total_length;
          state_d = ST_TX_REQ;
        end
      end
      ST_TX_REQ: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          rose_d     = 1'b0;
          to_cnt_d   = '0;
          state_d    = ST_TX_WAIT;
        end
      end
      // Wait for busy to rise then fall; give up if it never rises.
      ST_TX_WAIT: begin
        if (rose_q) begin
          if (!tx_busy) begin
            beacon_clr = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (tx_busy) begin
          rose_d = 1'b1;
        end else if (to_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Refused-packet accounting: rx_start anywhere but IDLE is a drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    drop_d     = drop_q;
    if (rx_done || rx_abort) drop_d = 1'b0;
    if (rx_start) begin
      if (state_q == ST_IDLE) begin
        drop_d = 1'b0;
      end else begin
        drop_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      tx_start_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      dlen_q      <= DEF_DATA_LEN;
      tlen_q      <= DEF_TOTAL_LEN;
      drop_cnt_q  <= '0;
      drop_q      <= 1'b0;
      rose_q      <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_start_q  <= tx_start_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      dlen_q      <= dlen_d;
      tlen_q      <= tlen_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_q      <= drop_d;
      rose_q      <= rose_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

`ifdef UDP_BEACON_EN
  // Beacon runs everywhere except during preload; cleared on tx completion.
  udp_beacon_timer #(.CYCLES(BEACON_CYCLES)) u_beacon (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != ST_INIT),
    .clr     (beacon_clr),
    .expired (beacon_exp)
  );
`else
  logic unused_beacon;
  assign beacon_exp    = 1'b0;
  assign unused_beacon = ^{beacon_clr, BEACON_CYCLES};
`endif

  assign tx_start        = tx_start_q;
  assign tx_data_length  = dlen_q;
  assign tx_total_length = tlen_q;
  assign ram_we          = ram_we_q;
  assign ram_waddr       = ram_waddr_q;
  assign ram_wdata       = ram_wdata_q;
  assign rx_drop_cnt     = drop_cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_udp_buf_ctrl.sv
// tb_udp_buf_ctrl: self-checking bench for udp_buf_ctrl (beacon part under UDP_BEACON_EN).
module tb_udp_buf_ctrl;

  localparam int AW  = 9;
  localparam int BCN = 1000;
  localparam int TMO = 16;
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_TX_WAIT = 3'd4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic rx_start = 1'b0, rx_wr_valid = 1'b0, rx_done = 1'b0, rx_abort = 1'b0, tx_busy = 1'b0;
  logic [AW-1:0] rx_wr_addr = '0;
  logic [31:0]   rx_wr_data = '0;
  logic [15:0]   rx_data_length = '0, rx_total_length = '0;
  logic          tx_start, ram_we;
  logic [15:0]   tx_data_length, tx_total_length, rx_drop_cnt;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [2:0]    state_o;

  udp_buf_ctrl #(.RAM_AW(AW), .PRELOAD_BASE(1), .BEACON_CYCLES(BCN), .TX_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_start(rx_start), .rx_wr_valid(rx_wr_valid),
    .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data), .rx_done(rx_done), .rx_abort(rx_abort),
    .rx_data_length(rx_data_length), .rx_total_length(rx_total_length), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rx_drop_cnt(rx_drop_cnt), .state_o(state_o));

  always #4 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    int n; logic [15:0] dl, tl; int kind;      // kind: 0 done, 1 abort, 2 both
    int exp_nwr; int exp_ntx; logic [15:0] exp_dl, exp_tl;
  } pkt_vec_t;

  wr_t      pre_tbl[5];
  pkt_vec_t pkt_tbl[5];
  logic [AW+31:0] wr_log[$], exp_wr[$];
  logic [31:0]    tx_log[$];
  int  n_tests = 0, n_fail = 0, tx_dbl = 0, busy_len = 50;
  bit  tx_resp_en = 1'b1, prev_tx = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed RAM writes and tx requests.
  always @(negedge clk) begin
    if (ram_we === 1'b1)  wr_log.push_back({ram_waddr, ram_wdata});
    if (tx_start === 1'b1) tx_log.push_back({tx_data_length, tx_total_length});
    if (tx_start === 1'b1 && prev_tx) tx_dbl <= tx_dbl + 1;
    prev_tx <= (tx_start === 1'b1);
  end

  // Tx engine model: busy one cycle after tx_start, for busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1 && tx_resp_en) begin
      @(negedge clk); tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int n = 0;
    while (state_o !== s && n < bound) begin @(negedge clk); n++; end
    chk({name, " wait_state"}, state_o, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; rx_start = 1'b0; rx_wr_valid = 1'b0; rx_done = 1'b0; rx_abort = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_preload(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("%s preload%0d", tag, i), {ram_we, ram_waddr, ram_wdata},
          {1'b1, pre_tbl[i].addr, pre_tbl[i].data});
    end
    @(negedge clk);
    chk({tag, " post_preload"}, {ram_we, state_o, tx_data_length, tx_total_length},
        {1'b0, S_IDLE, 16'd28, 16'd48});
  endtask

  task automatic send_pkt(input int n, input logic [15:0] dl, input logic [15:0] tl,
                          input int kind, input bit gappy);
    int i = 0;
    @(negedge clk); rx_start = 1'b1; rx_data_length = dl; rx_total_length = tl;
    @(negedge clk); rx_start = 1'b0;
    while (i < n) begin
      rx_wr_addr  = gappy ? AW'($urandom) : AW'(i);
      rx_wr_data  = $urandom;
      rx_wr_valid = !(gappy && $urandom_range(0, 3) == 0);
      if (rx_wr_valid) begin exp_wr.push_back({rx_wr_addr, rx_wr_data}); i++; end
      @(negedge clk);
    end
    rx_wr_valid = 1'b0;
    rx_done = (kind != 1); rx_abort = (kind != 0);
    @(negedge clk); rx_done = 1'b0; rx_abort = 1'b0;
    if (kind != 0) for (int k = 0; k < 5; k++) exp_wr.push_back({pre_tbl[k].addr, pre_tbl[k].data});
  endtask

  task automatic run_pkt(input string tag, input int n, input logic [15:0] dl, input logic [15:0] tl,
                         input int kind, input bit gappy, input int exp_nwr, input int exp_ntx,
                         input logic [15:0] edl, input logic [15:0] etl);
    int mism = 0;
    wait_state(S_IDLE, 500, tag);
    @(negedge clk);
    wr_log.delete(); tx_log.delete(); exp_wr.delete();
    send_pkt(n, dl, tl, kind, gappy);
    wait_state(S_IDLE, 500, tag);
    repeat (2) @(negedge clk);
    chk({tag, " nwr"}, wr_log.size(), exp_nwr);
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      if (wr_log[i] !== exp_wr[i]) mism++;
    chk({tag, " wdata"}, mism, 0);
    chk({tag, " ntx"}, tx_log.size(), exp_ntx);
    if (exp_ntx > 0 && tx_log.size() > 0) chk({tag, " txlen"}, tx_log[0], {edl, etl});
    chk({tag, " len"}, {tx_data_length, tx_total_length}, {edl, etl});
    chk({tag, " drop"}, rx_drop_cnt, 0);
  endtask

  initial begin
    logic [31:0] d;
    int n, kind;
    logic [15:0] dl, tl, mdl, mtl;

    pre_tbl[0] = '{9'd1, 32'h48454C4C};
    pre_tbl[1] = '{9'd2, 32'h4F20414C};
    pre_tbl[2] = '{9'd3, 32'h494E5820};
    pre_tbl[3] = '{9'd4, 32'h41583531};
    pre_tbl[4] = '{9'd5, 32'h36200A0D};
    pkt_tbl[0] = '{8, 16'd36,    16'd56,    0, 8, 1, 16'd36,    16'd56};
    pkt_tbl[1] = '{3, 16'd100,   16'd120,   1, 8, 0, 16'd28,    16'd48};
    pkt_tbl[2] = '{4, 16'd200,   16'd220,   2, 9, 0, 16'd28,    16'd48};
    pkt_tbl[3] = '{0, 16'd8,     16'd28,    0, 0, 1, 16'd8,     16'd28};
    pkt_tbl[4] = '{1, 16'hFFFF,  16'h1234,  0, 1, 1, 16'hFFFF,  16'h1234};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset state", {state_o, ram_we, ram_waddr, ram_wdata, tx_start},
        {S_INIT, 1'b0, 9'd0, 32'd0, 1'b0});
    chk("reset lengths", {tx_data_length, tx_total_length, rx_drop_cnt}, {16'd28, 16'd48, 16'd0});
    reset_n = 1'b1;
    check_preload("boot");

    // Echo with 1-cycle write latency, addresses 0..7.
    @(negedge clk); rx_start = 1'b1; rx_data_length = 16'd36; rx_total_length = 16'd56;
    @(negedge clk); rx_start = 1'b0;
    chk("lat idle_we", ram_we, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = $urandom; rx_wr_valid = 1'b1; rx_wr_addr = AW'(i); rx_wr_data = d;
      @(negedge clk);
      chk($sformatf("lat word%0d", i), {ram_we, ram_waddr, ram_wdata}, {1'b1, AW'(i), d});
    end
    rx_wr_valid = 1'b0; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("echo tx_start", tx_start, 1'b1);
    chk("echo txlen", {tx_data_length, tx_total_length}, {16'd36, 16'd56});
    wait_state(S_IDLE, 200, "echo");

    // Table-driven packets.
    do_reset(); check_preload("tbl");
    for (int t = 0; t < 5; t++)
      run_pkt($sformatf("tbl%0d", t), pkt_tbl[t].n, pkt_tbl[t].dl, pkt_tbl[t].tl, pkt_tbl[t].kind,
              1'b0, pkt_tbl[t].exp_nwr, pkt_tbl[t].exp_ntx, pkt_tbl[t].exp_dl, pkt_tbl[t].exp_tl);

    // rx_start while transmitting is refused.
    do_reset(); check_preload("drop");
    busy_len = 50;
    @(negedge clk);
    tx_log.delete();
    send_pkt(2, 16'd36, 16'd56, 0, 1'b0);
    wait_state(S_TX_WAIT, 20, "drop");
    wr_log.delete();
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_wr_valid = 1'b1; rx_wr_addr = AW'(i); rx_wr_data = $urandom;
      @(negedge clk);
    end
    rx_wr_valid = 1'b0; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    @(negedge clk);
    chk("drop state", state_o, S_TX_WAIT);
    chk("drop cnt", rx_drop_cnt, 16'd1);
    chk("drop no_we", wr_log.size(), 0);
    wait_state(S_IDLE, 200, "drop");
    @(negedge clk);
    chk("drop ntx", tx_log.size(), 1);

    // Reset in the middle of a packet.
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0; rx_wr_valid = 1'b1; rx_wr_addr = 9'd7; rx_wr_data = 32'hDEAD;
    @(negedge clk); rx_wr_valid = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset state", {state_o, ram_we, rx_drop_cnt}, {S_INIT, 1'b0, 16'd0});
    reset_n = 1'b1;
    check_preload("midreset");

    // Tx engine never responds: give up after TX_TIMEOUT cycles.
    tx_resp_en = 1'b0;
    send_pkt(1, 16'd40, 16'd60, 0, 1'b0);
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("tmo tx_start", tx_start, 1'b1);
    n = 0;
    while (state_o !== S_IDLE && n < 100) begin @(negedge clk); n++; end
    chk("tmo cycles", n, TMO);
    tx_resp_en = 1'b1;

`ifdef UDP_BEACON_EN
    // Beacon roughly every BEACON_CYCLES after idle / after tx completes.
    do_reset(); check_preload("bcn");
    busy_len = 50; tx_log.delete();
    n = 0;
    while (tx_start !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    if (n < 995 || n > 1010) begin n_fail++; $display("FAIL bcn first: %0d cycles, need ~%0d", n, BCN); end
    n_tests++;
    chk("bcn len", {tx_data_length, tx_total_length}, {16'd28, 16'd48});
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    while (tx_busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (tx_start !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    if (n < 995 || n > 1010) begin n_fail++; $display("FAIL bcn second: %0d cycles, need ~%0d", n, BCN); end
    n_tests++;
    wait_state(S_IDLE, 200, "bcn");
`else
    // No beacon: an idle controller never transmits.
    do_reset(); check_preload("nobcn");
    tx_log.delete();
    repeat (1200) @(negedge clk);
    chk("nobcn ntx", tx_log.size(), 0);
`endif

    // Randomized packets against a length/write-list model.
    for (int b = 0; b < 5; b++) begin
      do_reset(); check_preload($sformatf("rnd%0d", b));
      mdl = 16'd28; mtl = 16'd48;
      for (int p = 0; p < 4; p++) begin
        n = $urandom_range(0, 10);
        kind = $urandom_range(0, 9);
        kind = (kind < 7) ? 0 : (kind < 9) ? 1 : 2;
        dl = 16'($urandom); tl = 16'($urandom);
        busy_len = $urandom_range(3, 30);
        if (kind == 0) begin mdl = dl; mtl = tl; end
        else begin mdl = 16'd28; mtl = 16'd48; end
        run_pkt($sformatf("rnd%0d_%0d", b, p), n, dl, tl, kind, 1'b1,
                n + ((kind != 0) ? 5 : 0), (kind == 0) ? 1 : 0, mdl, mtl);
      end
    end

    chk("tx_start single cycle", tx_dbl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
